// File: rtl/fp_add_sequencer.sv
// Multi-cycle binary32 adder: compare/swap, iterative align, add, iterative normalise, pack.
// Optional macro FP_ADD_ROUND_NEAREST_EN selects round-to-nearest-even in PACK (default: truncate).
`timescale 1ns/1ps
module fp_add_sequencer #(
  parameter int EXP_W      = 8,
  parameter int MAN_W      = 23,
  parameter int ALIGN_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic               busy
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 3;   // hidden, mantissa, guard, sticky
  localparam int EW = EXP_W + 2;   // headroom for carry and overflow detection
  localparam logic [EXP_W-1:0] FAR_D   = EXP_W'(MAN_W + 3);
  localparam logic [EXP_W-1:0] STEP    = EXP_W'(ALIGN_STEP);
  localparam logic [EW-1:0]    EXP_MAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {IDLE, COMPARE, ALIGN, ADD, NORM, PACK, DONE} state_t;

  state_t           state;
  logic [W-1:0]     a_r, b_r;
  logic             sign_l, sign_s, zero_r;
  logic [EW-1:0]    exp_r;
  logic [EXP_W-1:0] d;
  logic [MW-1:0]    man_l, man_s;
  logic [MW:0]      sum;

  function automatic logic [MW-1:0] expand(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    return (e == '0) ? '0 : {1'b1, m, 2'b00};
  endfunction

  // Operand select mux: larger magnitude becomes L.
  logic             swap;
  logic [W-1:0]     l_word, s_word;
  logic [EXP_W-1:0] l_exp, s_exp, d_c;
  logic [MW-1:0]    s_man_c;
  always_comb begin
    swap   = (b_r[W-2 -: EXP_W] > a_r[W-2 -: EXP_W]) ||
             ((b_r[W-2 -: EXP_W] == a_r[W-2 -: EXP_W]) && (b_r[MAN_W-1:0] > a_r[MAN_W-1:0]));
    l_word = swap ? b_r : a_r;
    s_word = swap ? a_r : b_r;
    l_exp  = l_word[W-2 -: EXP_W];
    s_exp  = s_word[W-2 -: EXP_W];
    d_c    = l_exp - s_exp;
    s_man_c = expand(s_exp, s_word[MAN_W-1:0]);
  end

  // Alignment shift of up to ALIGN_STEP bits, folding lost bits into sticky.
  logic [EXP_W-1:0] step_c;
  logic [MW-1:0]    shifted;
  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    step_c  = (d < STEP) ? d : STEP;
    shifted = man_s;
    for (int i = 0; i < ALIGN_STEP; i++) begin
      if (EXP_W'(i) < step_c) shifted = {1'b0, shifted[MW-1:2], shifted[1] | shifted[0]};
    end
  end

  logic [MW:0] sum_c;
  always_comb begin
    if (sign_l == sign_s) sum_c = {1'b0, man_l} + {1'b0, man_s};
    else                  sum_c = {1'b0, man_l} - {1'b0, man_s};
  end

  logic [MAN_W-1:0] mant_p;
  logic [EW-1:0]    exp_p;
`ifdef FP_ADD_ROUND_NEAREST_EN
  logic             round_up;
  logic [MAN_W:0]   mant_rnd;
  always_comb begin
    round_up = sum[1] & (sum[0] | sum[2]);
    mant_rnd = {1'b0, sum[MW-2:2]} + (MAN_W+1)'(round_up);
    mant_p   = mant_rnd[MAN_W-1:0];
    exp_p    = exp_r + EW'(mant_rnd[MAN_W]);
  end
`else
  always_comb begin
    mant_p = sum[MW-2:2];
    exp_p  = exp_r;
  end
`endif

  logic [W-1:0] pack_c;
  always_comb begin
    if (zero_r)                pack_c = '0;
    else if (exp_p >= EXP_MAX) pack_c = {sign_l, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                       pack_c = {sign_l, exp_p[EXP_W-1:0], mant_p};
  end

  // NOTE: sequential state uses non-blocking assignments only; reset clears every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sign_l    <= 1'b0;
      sign_s    <= 1'b0;
      zero_r    <= 1'b0;
      exp_r     <= '0;
      d         <= '0;
      man_l     <= '0;
      man_s     <= '0;
      sum       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r      <= a;
          b_r      <= b;
          zero_r   <= 1'b0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= COMPARE;
        end
        COMPARE: begin
          sign_l <= l_word[W-1];
          sign_s <= s_word[W-1];
          exp_r  <= EW'(l_exp);
          man_l  <= expand(l_exp, l_word[MAN_W-1:0]);
          d      <= d_c;
          if (d_c >= FAR_D) begin
            man_s <= {{(MW-1){1'b0}}, |s_man_c};
            state <= ADD;
          end else begin
            man_s <= s_man_c;
            state <= (d_c == '0) ? ADD : ALIGN;
          end
        end
        ALIGN: begin
          man_s <= shifted;
          d     <= d - step_c;
          if (d == step_c) state <= ADD;
        end
        ADD: begin
          sum <= sum_c;
          if (sum_c[MW])          state <= NORM;
          else if (sum_c == '0) begin
            zero_r <= 1'b1;
            state  <= PACK;
          end
          else if (sum_c[MW-1])   state <= PACK;
          else                    state <= NORM;
        end
        NORM: begin
          if (sum[MW]) begin
            sum   <= {1'b0, sum[MW:2], sum[1] | sum[0]};
            exp_r <= exp_r + EW'(1);
            state <= PACK;
          end else if (sum[MW-1]) begin
            state <= PACK;
          end else if (exp_r <= EW'(1)) begin
            zero_r <= 1'b1;
            state  <= PACK;
          end else begin
            sum   <= {sum[MW-1:0], 1'b0};
            exp_r <= exp_r - EW'(1);
            if (sum[MW-2]) state <= PACK;
          end
        end
        PACK: begin
          result    <= pack_c;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer: reset, arithmetic vectors with latency, rounding, hold, mid-op reset.
`timescale 1ns/1ps
module tb_fp_add_sequencer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b, result;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  fp_add_sequencer #(.EXP_W(8), .MAN_W(23), .ALIGN_STEP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  localparam vec_t VECS [10] = '{
    '{32'h3F800000, 32'h3F800000, 32'h40000000, 4},
    '{32'h40400000, 32'hC0000000, 32'h3F800000, 4},
    '{32'h3FC00000, 32'hBFC00000, 32'h00000000, 3},
    '{32'h30800000, 32'h3F800000, 32'h3F800000, 3},
    '{32'h3FC00000, 32'h3FC00000, 32'h40400000, 4},
    '{32'hBF800000, 32'hBF800000, 32'hC0000000, 4},
    '{32'h40000000, 32'hBF800000, 32'h3F800000, 5},
    '{32'h00000000, 32'h40A00000, 32'h40A00000, 3},
    '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4},
    '{32'h00800000, 32'h80C00000, 32'h00000000, 4}
  };

  // Offers one operand pair, then waits (bounded) for out_valid; lat counts edges after accept.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: out_valid=0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'h0)   begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_arith();
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(VECS[i].a, VECS[i].b, res, lat);
      n_cmp++; if (res !== VECS[i].res) begin n_bad++;
        $display("FAIL arith%0d_result: got %h want %h", i, res, VECS[i].res); end
      n_cmp++; if (lat !== VECS[i].lat) begin n_bad++;
        $display("FAIL arith%0d_latency: got %0d want %0d", i, lat, VECS[i].lat); end
      consume();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
        $display("FAIL arith%0d_release: got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_round();
    logic [31:0] res, want;
    int lat;
    run_op(32'h3F800000, 32'h33800000, res, lat);
    n_cmp++; if (res !== 32'h3F800000) begin n_bad++; $display("FAIL round_tie: got %h want 3f800000", res); end
    n_cmp++; if (lat !== 27) begin n_bad++; $display("FAIL round_tie_latency: got %0d want 27", lat); end
    consume();
`ifdef FP_ADD_ROUND_NEAREST_EN
    want = 32'h3F800001;
`else
    want = 32'h3F800000;
`endif
    run_op(32'h3F800000, 32'h33C00000, res, lat);
    n_cmp++; if (res !== want) begin n_bad++; $display("FAIL round_above_half: got %h want %h", res, want); end
    n_cmp++; if (lat !== 27) begin n_bad++; $display("FAIL round_above_latency: got %0d want 27", lat); end
    consume();
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h40A00000; b = 32'h40A00000;
    repeat (2) begin
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_bad++;
        $display("FAIL busy_flags: got in_ready=%b busy=%b want 0/1", in_ready, busy); end
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'h40000000) begin n_bad++;
      $display("FAIL busy_ignore_result: got valid=%b result=%h want 1/40000000", out_valid, result); end
    consume();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL busy_no_extra_op: got out_valid=%b busy=%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_hold_and_reset();
    logic [31:0] res;
    int lat;
    run_op(32'h3F800000, 32'h3F800000, res, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold%0d_valid: got %b want 1", i, out_valid); end
      n_cmp++; if (result !== 32'h40000000) begin n_bad++; $display("FAIL hold%0d_result: got %h want 40000000", i, result); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold%0d_in_ready: got %b want 0", i, in_ready); end
    end
    consume();
    // Long-alignment transaction, interrupted while shifting.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h33800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_bad++;
      $display("FAIL mid_align_state: got busy=%b out_valid=%b want 1/0", busy, out_valid); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (result !== 32'h0)   begin n_bad++; $display("FAIL midrst_result: got %h want 0", result); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    @(negedge clk); rst = 1'b0;
    run_op(32'h40400000, 32'hC0000000, res, lat);
    n_cmp++; if (res !== 32'h3F800000) begin n_bad++; $display("FAIL post_reset_result: got %h want 3f800000", res); end
    consume();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_round();
    test_busy_ignore();
    test_hold_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
